// File: rtl/gcm_ct_collector.sv
// Ciphertext frame collector: packs up to MAX_BLKS strobed blocks plus a bypass header into frames queued for downstream.
// Optional build macro GCM_CT_BYTE_SWAP_EN byte-reverses each block on capture.
module gcm_ct_collector #(
  parameter int unsigned BLK_W    = 128,
  parameter int unsigned MAX_BLKS = 4,
  parameter int unsigned BYP_W    = 289,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_cp_ready,
  input  logic [0:BLK_W-1]            i_cipher_text,
  input  logic [BYP_W-1:0]            i_bypass_text,
  input  logic                        i_first,
  input  logic                        i_last,
  output logic [0:BLK_W*MAX_BLKS-1]   o_frame,
  output logic [BYP_W-1:0]            o_bypass_text,
  output logic [2:0]                  o_nblk,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_err,
  output logic [7:0]                  o_drop_cnt
);

  localparam int unsigned FRAME_W = BLK_W * MAX_BLKS;
  localparam int unsigned SLOT_W  = (MAX_BLKS > 1) ? $clog2(MAX_BLKS) : 1;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BLK_W-1:0]      r_blk [MAX_BLKS];
  logic [BYP_W-1:0]      r_byp;
  logic [SLOT_W-1:0]     r_idx;

  logic                  w_strobe;
  logic                  w_start;
  logic                  w_store;
  logic                  w_err;
  logic                  w_close;
  logic [SLOT_W-1:0]     w_slot;
  logic [BLK_W-1:0]      w_cap;
  logic [BLK_W-1:0]      w_asm [MAX_BLKS];
  logic [FRAME_W-1:0]    w_frame;
  logic [BYP_W-1:0]      w_byp;
  logic [2:0]            w_nblk;

  logic [FRAME_W-1:0]    r_mem_frame [DEPTH];
  logic [BYP_W-1:0]      r_mem_byp   [DEPTH];
  logic [2:0]            r_mem_nblk  [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_pop;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_drop;
  logic [PTR_W-1:0]      w_rd_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  logic [FRAME_W-1:0]    r_head_frame;
  logic [BYP_W-1:0]      r_head_byp;
  logic [2:0]            r_head_nblk;
  logic                  r_valid;
  logic                  r_err;
  logic [7:0]            r_drop_cnt;

  // Capture transform applied to every incoming block.
  function automatic logic [BLK_W-1:0] f_cap(input logic [BLK_W-1:0] b);
`ifdef GCM_CT_BYTE_SWAP_EN
    for (int i = 0; i < int'(BLK_W / 8); i++) begin
      f_cap[i*8 +: 8] = b[BLK_W-8-i*8 +: 8];
    end
`else
    f_cap = b;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (w_store) w_state_nxt = w_close ? S_IDLE : S_COLLECT;
  end

  // Decode: a first strobe always (re)starts a frame; stray or out-of-order strobes flag an error.
  always_comb begin
    w_strobe = i_cp_ready;
    w_start  = 1'b0;
    w_store  = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = w_strobe & i_first;
        w_store = w_strobe & i_first;
        w_err   = w_strobe & ~i_first;
      end
      S_COLLECT: begin
        w_start = w_strobe & i_first;
        w_store = w_strobe;
        w_err   = w_strobe & i_first;
      end
      default: ;
    endcase
    w_slot  = w_start ? '0 : r_idx;
    w_close = w_store & (i_last | (w_slot == SLOT_W'(MAX_BLKS - 1)));
  end

  // Assemble the frame as it stands including the current block; unused slots stay zero.
  always_comb begin
    w_cap = f_cap(i_cipher_text);
    for (int k = 0; k < int'(MAX_BLKS); k++) begin
      w_asm[k] = w_start ? '0 : r_blk[k];
    end
    w_asm[w_slot] = w_cap;
    w_frame = '0;
    for (int k = 0; k < int'(MAX_BLKS); k++) begin
      w_frame[FRAME_W-1-k*BLK_W -: BLK_W] = w_asm[k];
    end
    w_byp  = w_start ? i_bypass_text : r_byp;
    w_nblk = 3'(w_slot) + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_store) begin
      r_idx <= SLOT_W'(w_slot + SLOT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_blk <= w_asm;
      r_byp <= w_byp;
    end
  end

  // FIFO control: simultaneous pop frees the slot a full-FIFO push needs.
  always_comb begin
    w_pop     = r_valid & i_ready;
    w_full    = (r_cnt == CNT_W'(DEPTH));
    w_do_push = w_close & (~w_full | w_pop);
    w_drop    = w_close & w_full & ~w_pop;
    w_rd_nxt  = w_pop ? PTR_W'(r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    w_cnt_nxt = r_cnt + CNT_W'(w_do_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem_frame[r_wr_ptr] <= w_frame;
      r_mem_byp[r_wr_ptr]   <= w_byp;
      r_mem_nblk[r_wr_ptr]  <= w_nblk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= PTR_W'(r_wr_ptr + PTR_W'(1));
      r_rd_ptr <= w_rd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      r_err    <= w_err;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Registered head: next head comes from the incoming frame when it lands in the slot being exposed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head_frame <= '0;
      r_head_byp   <= '0;
      r_head_nblk  <= '0;
    end else if (w_cnt_nxt != '0) begin
      if (w_do_push && (r_wr_ptr == w_rd_nxt)) begin
        r_head_frame <= w_frame;
        r_head_byp   <= w_byp;
        r_head_nblk  <= w_nblk;
      end else begin
        r_head_frame <= r_mem_frame[w_rd_nxt];
        r_head_byp   <= r_mem_byp[w_rd_nxt];
        r_head_nblk  <= r_mem_nblk[w_rd_nxt];
      end
    end
  end

  assign o_frame       = r_head_frame;
  assign o_bypass_text = r_head_byp;
  assign o_nblk        = r_head_nblk;
  assign o_valid       = r_valid;
  assign o_err         = r_err;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_gcm_ct_collector.sv
// Scoreboard bench for gcm_ct_collector: directed frames, expected frames queued, a monitor checks each transfer.
module tb_gcm_ct_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_cp_ready;
  logic [127:0] i_cipher_text;
  logic [288:0] i_bypass_text;
  logic         i_first;
  logic         i_last;
  logic [511:0] o_frame;
  logic [288:0] o_bypass_text;
  logic [2:0]   o_nblk;
  logic         o_valid;
  logic         i_ready;
  logic         o_err;
  logic [7:0]   o_drop_cnt;

  typedef struct packed {
    logic [511:0] frame;
    logic [288:0] byp;
    logic [2:0]   nblk;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  gcm_ct_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cp_ready    (i_cp_ready),
    .i_cipher_text (i_cipher_text),
    .i_bypass_text (i_bypass_text),
    .i_first       (i_first),
    .i_last        (i_last),
    .o_frame       (o_frame),
    .o_bypass_text (o_bypass_text),
    .o_nblk        (o_nblk),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_err         (o_err),
    .o_drop_cnt    (o_drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] cap(input logic [127:0] b);
`ifdef GCM_CT_BYTE_SWAP_EN
    for (int i = 0; i < 16; i++) cap[i*8 +: 8] = b[120-i*8 +: 8];
`else
    cap = b;
`endif
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] n);
    blk = {32'hC0DE0000 | n, 32'h11110000 ^ n, 32'h2468ACE0 + n, 32'hF00D0000 | n};
  endfunction

  function automatic logic [288:0] byp(input logic [31:0] n);
    byp = {n[0], {9{32'hB1A50000 | n}}};
  endfunction

  function automatic logic [511:0] fr(input logic [127:0] b0, input logic [127:0] b1,
                                      input logic [127:0] b2, input logic [127:0] b3);
    fr = {cap(b0), cap(b1), cap(b2), cap(b3)};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [511:0] f, input logic [288:0] y, input logic [2:0] n);
    exp_t e;
    e.frame = f;
    e.byp   = y;
    e.nblk  = n;
    q.push_back(e);
  endtask

  task automatic strobe(input logic [127:0] b, input logic [288:0] y, input logic f, input logic l);
    i_cp_ready    = 1'b1;
    i_cipher_text = b;
    i_bypass_text = y;
    i_first       = f;
    i_last        = l;
    @(posedge clk); #1;
    i_cp_ready = 1'b0;
    i_first    = 1'b0;
    i_last     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got nblk %0d expected no frame", o_nblk);
      end else begin
        mon_e = q.pop_front();
        check("frame", o_frame, mon_e.frame);
        check("bypass", 512'(o_bypass_text), 512'(mon_e.byp));
        check("nblk", 512'(o_nblk), 512'(mon_e.nblk));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t2_blk;
    logic [127:0] t2_exp;
    t2_blk = 128'hD9313225F88406E5A55909C5AFF5269A;
`ifdef GCM_CT_BYTE_SWAP_EN
    t2_exp = 128'h9A26F5AFC50959A5E50684F8253231D9;
`else
    t2_exp = 128'hD9313225F88406E5A55909C5AFF5269A;
`endif
    rst_n = 1'b0; i_cp_ready = 1'b0; i_cipher_text = '0; i_bypass_text = '0;
    i_first = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    idle(2);
    check("rst_valid", 512'(o_valid), 512'(0));
    check("rst_err", 512'(o_err), 512'(0));
    check("rst_drop", 512'(o_drop_cnt), 512'(0));
    check("rst_nblk", 512'(o_nblk), 512'(0));
    check("rst_frame", o_frame, 512'(0));
    check("rst_bypass", 512'(o_bypass_text), 512'(0));
    rst_n = 1'b1;
    idle(1);

    // T1: four-block frame, bypass from first strobe, one-cycle latency
    i_ready = 1'b1;
    push_exp(fr(blk(1), blk(2), blk(3), blk(4)), byp(1), 3'd4);
    strobe(blk(1), byp(1), 1'b1, 1'b0);
    strobe(blk(2), byp(2), 1'b0, 1'b0);
    strobe(blk(3), byp(3), 1'b0, 1'b0);
    check("t1_valid_before", 512'(o_valid), 512'(0));
    strobe(blk(4), byp(4), 1'b0, 1'b1);
    check("t1_valid_after", 512'(o_valid), 512'(1));
    idle(3);
    check("t1_drained", 512'(o_valid), 512'(0));

    // T2: single-block frame, known vector
    push_exp({t2_exp, 384'h0}, byp(5), 3'd1);
    strobe(t2_blk, byp(5), 1'b1, 1'b1);
    idle(3);

    // T3: stall, third frame dropped, then drain in order
    i_ready = 1'b0;
    push_exp(fr(blk(10), '0, '0, '0), byp(10), 3'd1);
    push_exp(fr(blk(11), '0, '0, '0), byp(11), 3'd1);
    strobe(blk(10), byp(10), 1'b1, 1'b1);
    strobe(blk(11), byp(11), 1'b1, 1'b1);
    strobe(blk(12), byp(12), 1'b1, 1'b1);
    check("t3_drop", 512'(o_drop_cnt), 512'(1));
    check("t3_valid_full", 512'(o_valid), 512'(1));
    i_ready = 1'b1;
    idle(4);
    check("t3_drained", 512'(o_valid), 512'(0));

    // T4: full FIFO, push and pop same cycle; still full afterwards
    i_ready = 1'b0;
    push_exp(fr(blk(20), '0, '0, '0), byp(20), 3'd1);
    push_exp(fr(blk(21), '0, '0, '0), byp(21), 3'd1);
    strobe(blk(20), byp(20), 1'b1, 1'b1);
    strobe(blk(21), byp(21), 1'b1, 1'b1);
    push_exp(fr(blk(22), '0, '0, '0), byp(22), 3'd1);
    i_ready = 1'b1;
    strobe(blk(22), byp(22), 1'b1, 1'b1);
    i_ready = 1'b0;
    check("t4_no_drop", 512'(o_drop_cnt), 512'(1));
    check("t4_valid", 512'(o_valid), 512'(1));
    strobe(blk(23), byp(23), 1'b1, 1'b1);
    check("t4_still_full", 512'(o_drop_cnt), 512'(2));
    i_ready = 1'b1;
    idle(4);
    check("t4_drained", 512'(o_valid), 512'(0));

    // T5: protocol errors, restart on first, auto-close at four then stray block
    strobe(blk(30), byp(30), 1'b1, 1'b0);
    strobe(blk(31), byp(31), 1'b0, 1'b0);
    check("t5_no_err", 512'(o_err), 512'(0));
    strobe(blk(32), byp(32), 1'b1, 1'b0);
    check("t5_err_restart", 512'(o_err), 512'(1));
    push_exp(fr(blk(32), blk(33), '0, '0), byp(32), 3'd2);
    strobe(blk(33), byp(33), 1'b0, 1'b1);
    check("t5_err_pulse", 512'(o_err), 512'(0));
    idle(2);
    strobe(blk(34), byp(34), 1'b0, 1'b0);
    check("t5_err_idle", 512'(o_err), 512'(1));
    idle(1);
    check("t5_err_clear", 512'(o_err), 512'(0));
    push_exp(fr(blk(40), blk(41), blk(42), blk(43)), byp(40), 3'd4);
    strobe(blk(40), byp(40), 1'b1, 1'b0);
    strobe(blk(41), byp(41), 1'b0, 1'b0);
    strobe(blk(42), byp(42), 1'b0, 1'b0);
    strobe(blk(43), byp(43), 1'b0, 1'b0);
    check("t5_autoclose_valid", 512'(o_valid), 512'(1));
    strobe(blk(44), byp(44), 1'b0, 1'b0);
    check("t5_err_fifth", 512'(o_err), 512'(1));
    idle(3);
    check("t5_drained", 512'(o_valid), 512'(0));

    // T6: reset mid-frame with a queued frame
    i_ready = 1'b0;
    strobe(blk(50), byp(50), 1'b1, 1'b1);
    strobe(blk(51), byp(51), 1'b1, 1'b0);
    strobe(blk(52), byp(52), 1'b0, 1'b0);
    check("t6_queued", 512'(o_valid), 512'(1));
    q.delete();
    rst_n = 1'b0;
    idle(1);
    check("t6_rst_valid", 512'(o_valid), 512'(0));
    check("t6_rst_drop", 512'(o_drop_cnt), 512'(0));
    check("t6_rst_err", 512'(o_err), 512'(0));
    rst_n = 1'b1;
    i_ready = 1'b1;
    push_exp(fr(blk(60), blk(61), blk(62), '0), byp(60), 3'd3);
    strobe(blk(60), byp(60), 1'b1, 1'b0);
    strobe(blk(61), byp(61), 1'b0, 1'b0);
    strobe(blk(62), byp(62), 1'b0, 1'b1);
    idle(3);
    check("t6_drained", 512'(o_valid), 512'(0));

    check("queue_empty", 512'(q.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
